multi_stream_fifo: RTL and testbench

Parametrised multi-stream FIFO: a single tagged write port distributes words into FLUX independent circular queues, and a single read port drains them either by external per-stream select or by an internal round-robin arbiter. It sits between a tag-producing dataflow actor and consumers sharing one output bus. Over the single-write/per-stream-read FIFO it adds:

- per-stream occupancy counters and almost-full flags;
- registered output with valid and tag qualifiers;
- overflow, underflow and bad-tag error reporting;
- a selectable arbitrated drain mode.

---
 rtl/multi_stream_fifo_pkg.sv | 22 ++
 rtl/multi_stream_fifo_rr_arbiter.sv | 51 +++++
 rtl/multi_stream_fifo.sv | 152 +++++++++++++++
 tb/tb_multi_stream_fifo.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_stream_fifo_pkg.sv
// Shared constants and width helpers for the multi-stream FIFO slice.
package multi_stream_fifo_pkg;

  localparam int unsigned RD_MODE_SEL = 0;
  localparam int unsigned RD_MODE_RR  = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic int unsigned tag_w(input int unsigned flux);
    return clog2(flux);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/multi_stream_fifo_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last granted index.
module rr_arbiter #(
  parameter int unsigned FLUX  = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic [FLUX-1:0]  req,
  input  logic             advance,
  output logic [FLUX-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] last_grant;
  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Lowest requester above last_grant wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_found  = 1'b0;
    lo_found  = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    grant     = '0;
    for (int unsigned i = 0; i < FLUX; i++) begin
      if (req[i] && !hi_found && (i > 32'(last_grant))) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
      if (req[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
    for (int unsigned i = 0; i < FLUX; i++) begin
      grant[i] = (hi_found || lo_found) && (32'(grant_idx) == i);
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDX_W'(FLUX - 1);
    end else if (advance && |grant) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/multi_stream_fifo.sv
// Tagged single-write, multi-queue FIFO with registered read port,
// per-stream status/levels, sticky error flags and optional round-robin drain.
module multi_stream_fifo
  import multi_stream_fifo_pkg::*;
#(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned DEPTH   = 4,
  parameter  int unsigned FLUX    = 2,
  parameter  int unsigned AFULL   = DEPTH - 1,
  parameter  int unsigned RD_MODE = RD_MODE_SEL,
  localparam int unsigned TAG_W   = tag_w(FLUX),
  localparam int unsigned CNT_W   = cnt_w(DEPTH)
) (
  input  logic                  ck,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      datain,
  input  logic [FLUX-1:0]       rd,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      dataout,
  output logic                  dout_valid,
  output logic [TAG_W-1:0]      dout_tag,
  output logic [FLUX-1:0]       full,
  output logic [FLUX-1:0]       empty,
  output logic [FLUX-1:0]       almost_full,
  output logic [FLUX*CNT_W-1:0] level,
  output logic [FLUX-1:0]       overflow,
  output logic [FLUX-1:0]       underflow,
  output logic                  bad_tag
);

  localparam int unsigned ADDR_W = clog2(DEPTH);

  logic [WIDTH-1:0]  mem [FLUX][DEPTH];
  logic [ADDR_W-1:0] wp  [FLUX];
  logic [ADDR_W-1:0] rp  [FLUX];
  logic [CNT_W-1:0]  lvl [FLUX];

  logic [TAG_W-1:0]  wr_tag;
  logic              tag_ok;
  logic [FLUX-1:0]   wr_hit, wr_ok, ovf_evt;
  logic [FLUX-1:0]   rd_ok, udf_evt;
  logic [TAG_W-1:0]  rd_idx;

  assign wr_tag = datain[WIDTH-1 -: TAG_W];

  if ((32'd1 << TAG_W) == FLUX) begin : g_tag_full
    assign tag_ok = 1'b1;
  end else begin : g_tag_chk
    assign tag_ok = 32'(wr_tag) < FLUX;
  end

  always_comb begin
    full        = '0;
    empty       = '0;
    almost_full = '0;
    level       = '0;
    wr_hit      = '0;
    wr_ok       = '0;
    ovf_evt     = '0;
    for (int unsigned i = 0; i < FLUX; i++) begin
      full[i]                  = lvl[i] == CNT_W'(DEPTH);
      empty[i]                 = lvl[i] == '0;
      almost_full[i]           = lvl[i] >= CNT_W'(AFULL);
      level[i*CNT_W +: CNT_W]  = lvl[i];
      wr_hit[i]                = wr && tag_ok && (32'(wr_tag) == i);
      wr_ok[i]                 = wr_hit[i] && !full[i];
      ovf_evt[i]               = wr_hit[i] && full[i];
    end
  end

  if (RD_MODE == RD_MODE_RR) begin : g_rr
    logic [FLUX-1:0] grant;
    logic            unused_rd;
    assign unused_rd = ^rd;

    rr_arbiter #(
      .FLUX  (FLUX),
      .IDX_W (TAG_W)
    ) u_arb (
      .ck        (ck),
      .rst_n     (rst_n),
      .req       (~empty),
      .advance   (rd_en),
      .grant     (grant),
      .grant_idx (rd_idx)
    );

    assign rd_ok   = rd_en ? grant : '0;
    assign udf_evt = '0;
  end else begin : g_sel
    logic [FLUX-1:0] rd_pick;
    logic            found;
    logic            unused_rd_en;
    assign unused_rd_en = rd_en;

    always_comb begin
      rd_pick = '0;
      rd_idx  = '0;
      found   = 1'b0;
      for (int unsigned i = 0; i < FLUX; i++) begin
        if (rd[i] && !found) begin
          found      = 1'b1;
          rd_pick[i] = 1'b1;
          rd_idx     = TAG_W'(i);
        end
      end
    end

    assign rd_ok   = rd_pick & ~empty;
    assign udf_evt = rd_pick & empty;
  end

  always_ff @(posedge ck) begin
    for (int unsigned i = 0; i < FLUX; i++) begin
      if (wr_ok[i]) mem[i][wp[i]] <= datain;
    end
  end

  // Decisions use pre-edge full/empty, so a same-cycle read never frees room for the write.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FLUX; i++) begin
        wp[i]  <= '0;
        rp[i]  <= '0;
        lvl[i] <= '0;
      end
      dataout    <= '0;
      dout_tag   <= '0;
      dout_valid <= 1'b0;
      overflow   <= '0;
      underflow  <= '0;
      bad_tag    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < FLUX; i++) begin
        if (wr_ok[i]) wp[i] <= wp[i] + 1'b1;
        if (rd_ok[i]) rp[i] <= rp[i] + 1'b1;
        lvl[i] <= lvl[i] + CNT_W'(wr_ok[i]) - CNT_W'(rd_ok[i]);
      end
      dout_valid <= |rd_ok;
      if (|rd_ok) begin
        dataout  <= mem[rd_idx][rp[rd_idx]];
        dout_tag <= rd_idx;
      end
      overflow  <= ovf_evt | (overflow & ~{FLUX{clr_err}});
      underflow <= udf_evt | (underflow & ~{FLUX{clr_err}});
      bad_tag   <= (wr && !tag_ok) | (bad_tag && !clr_err);
    end
  end

endmodule

// File: tb/tb_multi_stream_fifo.sv
// Bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_multi_stream_fifo;

  logic ck = 1'b0;
  always #5 ck = ~ck;
  logic rst_n;

  // Instance A: FLUX=2, external select
  logic       wr_a, clr_a;
  logic [7:0] din_a;
  logic [1:0] rd_a;
  logic       rden_a;
  logic [7:0] dout_a;
  logic       dv_a, dtag_a, bad_a;
  logic [1:0] full_a, empty_a, af_a, ovf_a, udf_a;
  logic [5:0] lvl_a;

  // Instance B: FLUX=3, round-robin drain
  logic       wr_b, clr_b, rden_b;
  logic [7:0] din_b;
  logic [2:0] rd_b;
  logic [7:0] dout_b;
  logic       dv_b, bad_b;
  logic [1:0] dtag_b;
  logic [2:0] full_b, empty_b, af_b, ovf_b, udf_b;
  logic [8:0] lvl_b;

  multi_stream_fifo #(
    .WIDTH(8), .DEPTH(4), .FLUX(2), .AFULL(3), .RD_MODE(0)
  ) u_a (
    .ck(ck), .rst_n(rst_n), .wr(wr_a), .datain(din_a), .rd(rd_a), .rd_en(rden_a),
    .clr_err(clr_a), .dataout(dout_a), .dout_valid(dv_a), .dout_tag(dtag_a),
    .full(full_a), .empty(empty_a), .almost_full(af_a), .level(lvl_a),
    .overflow(ovf_a), .underflow(udf_a), .bad_tag(bad_a)
  );

  multi_stream_fifo #(
    .WIDTH(8), .DEPTH(4), .FLUX(3), .AFULL(3), .RD_MODE(1)
  ) u_b (
    .ck(ck), .rst_n(rst_n), .wr(wr_b), .datain(din_b), .rd(rd_b), .rd_en(rden_b),
    .clr_err(clr_b), .dataout(dout_b), .dout_valid(dv_b), .dout_tag(dtag_b),
    .full(full_b), .empty(empty_b), .almost_full(af_b), .level(lvl_b),
    .overflow(ovf_b), .underflow(udf_b), .bad_tag(bad_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue per stream, index k*3+s (k=0 for A, k=1 for B)
  logic [7:0] mq [6][$];
  logic       m_dv   [2];
  logic [1:0] m_tag  [2];
  logic [7:0] m_dout [2];
  logic [2:0] m_ovf  [2];
  logic [2:0] m_udf  [2];
  logic       m_bad  [2];
  int         m_lg;

  task automatic model_reset();
    for (int i = 0; i < 6; i++) mq[i].delete();
    for (int k = 0; k < 2; k++) begin
      m_dv[k] = 1'b0; m_tag[k] = '0; m_dout[k] = '0;
      m_ovf[k] = '0;  m_udf[k] = '0; m_bad[k] = 1'b0;
    end
    m_lg = 2;
  endtask

  task automatic model_step(input int k);
    int nf, t, sel, cand;
    int sz [3];
    logic w, c, re, rok, be;
    logic [7:0] d;
    logic [1:0] rdv;
    logic [2:0] oe, ue;
    nf = (k == 0) ? 2 : 3;
    if (k == 0) begin
      w = wr_a; d = din_a; c = clr_a; rdv = rd_a; re = 1'b0; t = int'(d[7]);
    end else begin
      w = wr_b; d = din_b; c = clr_b; rdv = '0; re = rden_b; t = int'(d[7:6]);
    end
    for (int s = 0; s < 3; s++) sz[s] = mq[k*3+s].size();
    oe = '0; ue = '0; be = 1'b0; rok = 1'b0; sel = 0;
    if (w) begin
      if (t >= nf) be = 1'b1;
      else if (sz[t] == 4) oe[t] = 1'b1;
    end
    if (k == 0) begin
      if (rdv != 2'b00) begin
        sel = rdv[0] ? 0 : 1;
        if (sz[sel] == 0) ue[sel] = 1'b1;
        else rok = 1'b1;
      end
    end else if (re) begin
      for (int off = 1; off <= nf; off++) begin
        cand = (m_lg + off) % nf;
        if (!rok && sz[cand] > 0) begin
          rok = 1'b1;
          sel = cand;
        end
      end
    end
    if (rok) begin
      m_dout[k] = mq[k*3+sel].pop_front();
      m_tag[k]  = 2'(sel);
      if (k == 1) m_lg = sel;
    end
    m_dv[k] = rok;
    if (w && t < nf && sz[t] < 4) mq[k*3+t].push_back(d);
    if (c) begin
      m_ovf[k] = '0; m_udf[k] = '0; m_bad[k] = 1'b0;
    end
    m_ovf[k] = m_ovf[k] | oe;
    m_udf[k] = m_udf[k] | ue;
    m_bad[k] = m_bad[k] | be;
  endtask

  always @(negedge ck) begin : compare
    logic [8:0] el;
    logic [2:0] ef, ee, ea;
    int n;
    for (int k = 0; k < 2; k++) begin
      el = '0; ef = '0; ee = '0; ea = '0;
      for (int s = 0; s < ((k == 0) ? 2 : 3); s++) begin
        n = mq[k*3+s].size();
        el[s*3 +: 3] = 3'(n);
        ef[s] = (n == 4);
        ee[s] = (n == 0);
        ea[s] = (n >= 3);
      end
      if (k == 0) begin
        chk("A.level",  32'(lvl_a), 32'(el[5:0]));
        chk("A.status", 32'({full_a, empty_a, af_a}), 32'({ef[1:0], ee[1:0], ea[1:0]}));
        chk("A.out",    32'({dv_a, dtag_a, dout_a}), 32'({m_dv[0], m_tag[0][0], m_dout[0]}));
        chk("A.err",    32'({ovf_a, udf_a, bad_a}), 32'({m_ovf[0][1:0], m_udf[0][1:0], m_bad[0]}));
      end else begin
        chk("B.level",  32'(lvl_b), 32'(el));
        chk("B.status", 32'({full_b, empty_b, af_b}), 32'({ef, ee, ea}));
        chk("B.out",    32'({dv_b, dtag_b, dout_b}), 32'({m_dv[1], m_tag[1], m_dout[1]}));
        chk("B.err",    32'({ovf_b, udf_b, bad_b}), 32'({m_ovf[1], m_udf[1], m_bad[1]}));
      end
    end
  end

  task automatic tick();
    @(posedge ck);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    #1;
  endtask

  task automatic idle();
    wr_a = 1'b0; rd_a = '0; clr_a = 1'b0;
    wr_b = 1'b0; rden_b = 1'b0; clr_b = 1'b0;
  endtask

  logic [1:0] rr_exp [5];

  initial begin
    rden_a = 1'b0; rd_b = '0;
    idle();
    din_a = '0; din_b = '0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst.level_a", 32'(lvl_a), 32'h0);
    chk("rst.empty",   32'({empty_a, empty_b, full_a, af_a}), 32'({2'b11, 3'b111, 2'b00, 2'b00}));
    chk("rst.out_a",   32'({dv_a, dtag_a, dout_a}), 32'h0);
    rst_n = 1'b1;

    // Basic write then read order
    wr_a = 1'b1; din_a = 8'h01; tick();
    din_a = 8'h02; tick();
    din_a = 8'h83; tick();
    wr_a = 1'b0;
    chk("t1.level", 32'(lvl_a), 32'(6'b001_010));
    rd_a = 2'b01; tick();
    chk("t1.rd0", 32'({dv_a, dtag_a, dout_a}), 32'({1'b1, 1'b0, 8'h01}));
    tick();
    chk("t1.rd1", 32'({dv_a, dtag_a, dout_a}), 32'({1'b1, 1'b0, 8'h02}));
    rd_a = 2'b10; tick();
    chk("t1.rd2", 32'({dv_a, dtag_a, dout_a}), 32'({1'b1, 1'b1, 8'h83}));
    rd_a = 2'b00; tick();
    chk("t1.idle", 32'({dv_a, dout_a}), 32'({1'b0, 8'h83}));

    // Fill stream 0 past capacity
    wr_a = 1'b1;
    din_a = 8'h10; tick();
    din_a = 8'h11; tick();
    din_a = 8'h12; tick();
    chk("t2.afull", 32'({full_a, af_a}), 32'({2'b00, 2'b01}));
    din_a = 8'h13; tick();
    chk("t2.full", 32'(full_a), 32'(2'b01));
    din_a = 8'h14; tick();
    chk("t2.ovf", 32'({ovf_a, lvl_a}), 32'({2'b01, 6'b000_100}));
    wr_a = 1'b0;

    // Full + read, then half-full write+read
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    chk("t3.clr", 32'(ovf_a), 32'h0);
    wr_a = 1'b1; din_a = 8'h15; rd_a = 2'b01; tick();
    chk("t3.fullrd", 32'({ovf_a, lvl_a, dv_a, dout_a}), 32'({2'b01, 6'b000_011, 1'b1, 8'h10}));
    din_a = 8'h16; tick();
    chk("t3.wrrd", 32'({lvl_a, dout_a}), 32'({6'b000_011, 8'h11}));
    wr_a = 1'b0;
    repeat (3) tick();
    chk("t3.order", 32'({lvl_a, dv_a, dout_a}), 32'({6'b000_000, 1'b1, 8'h16}));
    rd_a = 2'b00;

    // Priority select, underflow, clear vs event
    wr_a = 1'b1; din_a = 8'h05; tick();
    din_a = 8'h85; tick();
    wr_a = 1'b0; rd_a = 2'b11; tick();
    chk("t4.prio", 32'({dv_a, dtag_a, dout_a, lvl_a}), 32'({1'b1, 1'b0, 8'h05, 6'b001_000}));
    rd_a = 2'b01; tick();
    chk("t4.udf", 32'({dv_a, udf_a}), 32'(3'b001));
    rd_a = 2'b00; clr_a = 1'b1; tick();
    chk("t4.clr", 32'(udf_a), 32'h0);
    rd_a = 2'b01; tick();
    chk("t4.clrprio", 32'(udf_a), 32'(2'b01));
    clr_a = 1'b0; wr_a = 1'b1; din_a = 8'h07; tick();
    chk("t4.emptywr", 32'({dv_a, lvl_a}), 32'({1'b0, 6'b001_001}));
    wr_a = 1'b0; rd_a = 2'b11; tick();
    chk("t4.rd07", 32'({dv_a, dout_a}), 32'({1'b1, 8'h07}));
    rd_a = 2'b10; tick();
    chk("t4.rd85", 32'({dv_a, dtag_a, dout_a}), 32'({1'b1, 1'b1, 8'h85}));
    rd_a = 2'b00;

    // Round-robin drain on B
    wr_b = 1'b1;
    din_b = 8'h01; tick();
    din_b = 8'h02; tick();
    din_b = 8'h03; tick();
    din_b = 8'h41; tick();
    din_b = 8'h42; tick();
    wr_b = 1'b0;
    chk("t5.level", 32'(lvl_b), 32'(9'b000_010_011));
    rr_exp[0] = 2'd0; rr_exp[1] = 2'd1; rr_exp[2] = 2'd0; rr_exp[3] = 2'd1; rr_exp[4] = 2'd0;
    rden_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5.rr", 32'({dv_b, dtag_b}), 32'({1'b1, rr_exp[i]}));
    end
    tick();
    chk("t5.drained", 32'({dv_b, empty_b}), 32'({1'b0, 3'b111}));
    rden_b = 1'b0;

    // Bad tag on FLUX=3
    wr_b = 1'b1; din_b = 8'hC0; tick(); wr_b = 1'b0;
    chk("t6.badtag", 32'({bad_b, lvl_b}), 32'({1'b1, 9'h000}));

    // Asynchronous reset mid-burst
    wr_a = 1'b1; din_a = 8'h21; rd_a = 2'b01;
    wr_b = 1'b1; din_b = 8'h05; rden_b = 1'b1;
    tick();
    din_a = 8'h22; tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t7.rst_a", 32'({lvl_a, empty_a, dv_a, dtag_a, dout_a, ovf_a, udf_a}),
        32'({6'h00, 2'b11, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00}));
    chk("t7.rst_b", 32'({bad_b, lvl_b, empty_b, dv_b}), 32'({1'b0, 9'h000, 3'b111, 1'b0}));
    idle();
    tick(); tick();
    rst_n = 1'b1;
    rd_a = 2'b01; tick();
    chk("t7.postudf", 32'({dv_a, udf_a}), 32'(3'b001));
    rd_a = 2'b00; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
